// File: rtl/message_scroll_ctrl.sv
// message_scroll_ctrl
//   Steps a message-ROM character address once per tick, dwells on the last
//   character for HOLD_TICKS ticks, then either wraps to address 0 (loop_en=1)
//   or parks in DONE (loop_en=0).
//
// Parameters
//   HOLD_TICKS : ticks spent dwelling on the last character (1..15)
//
// Ports
//   clk_in     : system clock
//   reset      : asynchronous, active-high reset
//   tick       : one-cycle step enable
//   start      : begin/retrigger from address 0 (ignored when msg_len == 0)
//   stop       : abort to IDLE
//   pause      : level-sensitive freeze while RUN or HOLD
//   loop_en    : wrap (1) or finish (0) at the end of the dwell
//   msg_len    : message length, sampled on an accepted start, capped at 16
//   addr       : character address
//   addr_valid : addr meaningful (RUN, HOLD, DONE)
//   busy       : RUN or HOLD
//   paused     : pause && busy
//   wrap       : one-cycle pulse on the wrap back to address 0
//   done       : state is DONE
module message_scroll_ctrl #(
  parameter int unsigned HOLD_TICKS = 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  input  logic [4:0] msg_len,
  output logic [3:0] addr,
  output logic       addr_valid,
  output logic       busy,
  output logic       paused,
  output logic       wrap,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_TICKS - 1);

  state_t     state;
  logic [4:0] len_q;
  logic [3:0] hold_cnt;

  logic       start_ok;
  logic [4:0] len_sat;
  logic       at_last;

  assign start_ok = start && (msg_len != 5'd0);
  assign len_sat  = (msg_len > 5'd16) ? 5'd16 : msg_len;
  // 5-bit compare so len_q=16 targets address 15 without truncation games
  assign at_last  = ({1'b0, addr} == (len_q - 5'd1));

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      addr       <= '0;
      hold_cnt   <= '0;
      len_q      <= '0;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      paused     <= 1'b0;
      wrap       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (stop) begin
        state      <= S_IDLE;
        addr       <= '0;
        hold_cnt   <= '0;
        addr_valid <= 1'b0;
        busy       <= 1'b0;
        paused     <= 1'b0;
        done       <= 1'b0;
      end else if (start_ok) begin
        // start outranks pause and tick: always lands on address 0, no step
        state      <= S_RUN;
        addr       <= '0;
        hold_cnt   <= '0;
        len_q      <= len_sat;
        addr_valid <= 1'b1;
        busy       <= 1'b1;
        paused     <= pause;
        done       <= 1'b0;
      end else begin
        case (state)
          S_RUN: begin
            paused <= pause;
            if (!pause && tick) begin
              if (at_last) begin
                state    <= S_HOLD;
                hold_cnt <= '0;
              end else begin
                addr <= addr + 4'd1;
              end
            end
          end
          S_HOLD: begin
            paused <= pause;
            if (!pause && tick) begin
              if (hold_cnt == HOLD_LAST) begin
                hold_cnt <= '0;
                if (loop_en) begin
                  state <= S_RUN;
                  addr  <= '0;
                  wrap  <= 1'b1;
                end else begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end else begin
                hold_cnt <= hold_cnt + 4'd1;
              end
            end
          end
          S_IDLE, S_DONE: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_message_scroll_ctrl.sv
module tb_message_scroll_ctrl;

  localparam int unsigned HT = 2;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       tick, start, stop, pause, loop_en;
  logic [4:0] msg_len;
  logic [3:0] addr;
  logic       addr_valid, busy, paused, wrap, done;

  always #5 clk_in = ~clk_in;

  message_scroll_ctrl #(.HOLD_TICKS(HT)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop_en    (loop_en),
    .msg_len    (msg_len),
    .addr       (addr),
    .addr_valid (addr_valid),
    .busy       (busy),
    .paused     (paused),
    .wrap       (wrap),
    .done       (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a scrolling position, a count of ticks spent sitting on
  // the last character, and whether a scroll is active or finished.
  // Leaving the last character happens on the (HT+1)-th tick spent there.
  int m_len, m_pos, m_stay;
  bit m_run, m_fin, m_wrap, m_paused;

  task automatic model_reset();
    m_len = 0; m_pos = 0; m_stay = 0;
    m_run = 0; m_fin = 0; m_wrap = 0; m_paused = 0;
  endtask

  task automatic model_edge();
    m_wrap = 0;
    if (stop) begin
      m_run = 0; m_fin = 0; m_pos = 0; m_stay = 0;
    end else if (start && msg_len != 0) begin
      m_len  = (msg_len > 16) ? 16 : int'(msg_len);
      m_pos  = 0; m_stay = 0; m_run = 1; m_fin = 0;
    end else if (m_run && !pause && tick) begin
      if (m_pos < m_len - 1) m_pos++;
      else begin
        m_stay++;
        if (m_stay == int'(HT) + 1) begin
          m_stay = 0;
          if (loop_en) begin
            m_pos  = 0;
            m_wrap = 1;
          end else begin
            m_run = 0;
            m_fin = 1;
          end
        end
      end
    end
    m_paused = pause && m_run;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".addr"},   32'(addr),       32'(m_pos));
    check({tag, ".valid"},  32'(addr_valid), 32'(m_run || m_fin));
    check({tag, ".busy"},   32'(busy),       32'(m_run));
    check({tag, ".paused"}, 32'(paused),     32'(m_paused));
    check({tag, ".wrap"},   32'(wrap),       32'(m_wrap));
    check({tag, ".done"},   32'(done),       32'(m_fin));
  endtask

  // Called at posedge+1: drive inputs, predict, cross the edge, compare.
  task automatic cycle(input bit t, input bit s, input bit sp, input bit p,
                       input bit le, input logic [4:0] ml, input string tag);
    tick = t; start = s; stop = sp; pause = p; loop_en = le; msg_len = ml;
    model_edge();
    @(posedge clk_in);
    #1;
    compare_all(tag);
    tick = 0; start = 0; stop = 0;
  endtask

  initial begin
    int exp35 [8] = '{1, 2, 3, 4, 4, 4, 0, 1};
    int exp36 [6] = '{1, 2, 2, 2, 2, 2};

    reset = 1; tick = 0; start = 0; stop = 0; pause = 0; loop_en = 0; msg_len = '0;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk_in);
    reset = 0;
    @(posedge clk_in);
    #1;

    // len 5, looping
    cycle(0, 1, 0, 0, 1, 5'd5, "l5_start");
    check("l5_start_addr0", 32'(addr), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, 0, 1, 5'd5, $sformatf("l5_tick%0d", i + 1));
      check($sformatf("l5_seq%0d", i + 1), 32'(addr), 32'(exp35[i]));
      check($sformatf("l5_wrap%0d", i + 1), 32'(wrap), 32'(i == 6));
      cycle(0, 0, 0, 0, 1, 5'd5, "l5_gap");
    end

    // len 3, finishing; done lands on the tick closing the HT-tick dwell
    cycle(0, 1, 0, 0, 0, 5'd3, "l3_start");
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 0, 0, 0, 5'd3, $sformatf("l3_tick%0d", i + 1));
      check($sformatf("l3_seq%0d", i + 1), 32'(addr), 32'(exp36[i]));
      check($sformatf("l3_done%0d", i + 1), 32'(done), 32'(i >= 4));
    end

    // len 20 clamps to 16
    cycle(0, 1, 0, 0, 1, 5'd20, "l20_start");
    for (int i = 0; i < 15; i++) cycle(1, 0, 0, 0, 1, 5'd20, "l20_run");
    check("l20_addr15", 32'(addr), 32'd15);
    for (int i = 0; i < int'(HT) + 1; i++) cycle(1, 0, 0, 0, 1, 5'd20, "l20_hold");
    check("l20_wrap_addr0", 32'(addr), 32'd0);
    check("l20_wrap_pulse", 32'(wrap), 32'd1);

    // pause at address 2
    cycle(0, 1, 0, 0, 1, 5'd8, "p_start");
    cycle(1, 0, 0, 0, 1, 5'd8, "p_t1");
    cycle(1, 0, 0, 0, 1, 5'd8, "p_t2");
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 1, 5'd8, "p_frozen");
    check("p_addr2", 32'(addr), 32'd2);
    check("p_paused", 32'(paused), 32'd1);
    cycle(1, 0, 0, 0, 1, 5'd8, "p_resume");
    check("p_addr3", 32'(addr), 32'd3);

    // stop beats start; start with zero length is ignored
    cycle(1, 1, 1, 0, 1, 5'd8, "stop_start");
    check("ss_addr", 32'(addr), 32'd0);
    check("ss_valid", 32'(addr_valid), 32'd0);
    cycle(0, 1, 0, 0, 1, 5'd0, "zero_len");
    check("zl_valid", 32'(addr_valid), 32'd0);

    // async reset during the dwell
    cycle(0, 1, 0, 0, 1, 5'd5, "r_start");
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 1, 5'd5, "r_run");
    tick = 1; loop_en = 1;
    #2;
    reset = 1;
    model_reset();
    #1;
    compare_all("r_async");
    @(posedge clk_in);
    #1;
    compare_all("r_held");
    @(negedge clk_in);
    reset = 0; tick = 0;
    @(posedge clk_in);
    #1;
    check("r_nowrap", 32'(wrap), 32'd0);
    cycle(0, 1, 0, 0, 1, 5'd5, "r_restart");
    check("r_restart_addr", 32'(addr), 32'd0);
    check("r_restart_busy", 32'(busy), 32'd1);

    // randomized traffic, including len 1 and lengths above 16
    for (int i = 0; i < 4000; i++) begin
      bit rt, rs, rsp, rp, rle;
      logic [4:0] rml;
      rt  = ($urandom_range(0, 99) < 45);
      rs  = ($urandom_range(0, 99) < 4);
      rsp = ($urandom_range(0, 99) < 1);
      rp  = ($urandom_range(0, 99) < 10) ? ~pause : pause;
      rle = ($urandom_range(0, 99) < 70);
      rml = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      cycle(rt, rs, rsp, rp, rle, rml, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
